// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data access (DM).
// One access is outstanding at a time; read data is registered and flagged by a one-cycle ready.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ready,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

    localparam logic [2:0] Latency = 3'(MEM_LATENCY);

    state_e     state_q;
    logic [2:0] count_q;
    logic       last_dm_q;
    logic       cur_dm_q;
    logic       cur_we_q;

    logic if_elig;
    logic dm_elig;
    logic grant_dm;
    logic unused_addr_bits;

    // A port is masked in the cycle its own ready pulse is high.
    always_comb begin
        if_elig  = if_req & ~if_ready;
        dm_elig  = dm_req & ~dm_ready;
        grant_dm = dm_elig & (~if_elig | ~last_dm_q);
        // Held low during reset so every output reads 0 while reset is asserted.
        stall    = ~reset & (if_elig | dm_elig);
    end

    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= 3'd0;
            last_dm_q <= 1'b0;
            cur_dm_q  <= 1'b0;
            cur_we_q  <= 1'b0;
            if_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_ready  <= 1'b0;
            dm_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_elig | dm_elig) begin
                        state_q   <= StAccess;
                        count_q   <= Latency;
                        last_dm_q <= grant_dm;
                        cur_dm_q  <= grant_dm;
                        cur_we_q  <= grant_dm & dm_we;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_dm & dm_we;
                        if (grant_dm) begin
                            mem_addr  <= {dm_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata <= dm_wdata;
                        end else begin
                            mem_addr  <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                StAccess: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (count_q == 3'd1) begin
                        count_q <= 3'd0;
                        state_q <= StIdle;
                        if (cur_dm_q) begin
                            dm_ready <= 1'b1;
                            if (!cur_we_q) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        count_q <= count_q - 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (MEM_LATENCY >= 1 && MEM_LATENCY <= 4)
                else $error("mem_port_arbiter: MEM_LATENCY %0d outside 1..4", MEM_LATENCY);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance a (latency 1) runs directed and random traffic,
// instance b (latency 3) checks the longer latency and reset abort in the middle of an access.
module tb_mem_port_arbiter;

    localparam int LatA = 1;
    localparam int LatB = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } dm_item_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Instance a signals
    logic        reset_a, if_req_a, if_ready_a, dm_req_a, dm_we_a, dm_ready_a;
    logic        mem_en_a, mem_we_a, stall_a;
    logic [31:0] if_addr_a, if_rdata_a, dm_addr_a, dm_wdata_a, dm_rdata_a;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;

    // Instance b signals
    logic        reset_b, if_req_b, if_ready_b, dm_req_b, dm_we_b, dm_ready_b;
    logic        mem_en_b, mem_we_b, stall_b;
    logic [31:0] if_addr_b, if_rdata_b, dm_addr_b, dm_wdata_b, dm_rdata_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LatA)) dut_a (
        .clock(clock), .reset(reset_a),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_ready(if_ready_a), .if_rdata(if_rdata_a),
        .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
        .dm_ready(dm_ready_a), .dm_rdata(dm_rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a), .stall(stall_a)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LatB)) dut_b (
        .clock(clock), .reset(reset_b),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_ready(if_ready_b), .if_rdata(if_rdata_b),
        .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
        .dm_ready(dm_ready_b), .dm_rdata(dm_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .stall(stall_b)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 2) return 32'h8C02_0004;
        return 32'h1000_0000 + i * 32'h0001_0003;
    endfunction

    // Memory models: data is only valid in the cycle exactly Lat cycles after the mem_en cycle.
    logic [31:0] mem_a [256];
    logic [7:0]  word_a, word_b;
    logic [2:0]  age_a, age_b;

    always @(posedge clock) begin
        if (reset_a) begin
            age_a <= 3'd0;
            for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
        end else if (mem_en_a) begin
            age_a  <= 3'd1;
            word_a <= mem_addr_a[9:2];
            if (mem_we_a) mem_a[mem_addr_a[9:2]] <= mem_wdata_a;
        end else if (age_a != 3'd0 && age_a != 3'd7) begin
            age_a <= age_a + 3'd1;
        end
    end
    assign mem_rdata_a = (age_a == 3'(LatA)) ? mem_a[word_a] : (32'h5A5A_0000 | 32'(age_a));

    always @(posedge clock) begin
        if (reset_b) begin
            age_b <= 3'd0;
        end else if (mem_en_b) begin
            age_b  <= 3'd1;
            word_b <= mem_addr_b[9:2];
        end else if (age_b != 3'd0 && age_b != 3'd7) begin
            age_b <= age_b + 3'd1;
        end
    end
    assign mem_rdata_b = (age_b == 3'(LatB)) ? init_word(32'(word_b))
                                              : (32'h5A5A_0000 | 32'(age_b));

    // Reference model: plain word array plus per-port expected-response queues.
    logic [31:0] ref_mem [256];
    logic [31:0] dm_last;
    logic [31:0] if_q [$];
    dm_item_t    dm_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no ready within cycle budget (cycle %0d)", name, cyc);
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    // Monitor for instance a: pops expectations on every ready pulse.
    initial begin : monitor_a
        int       en_cyc, if_foreign, dm_foreign;
        logic     prev_en;
        dm_item_t it;
        logic [31:0] want;
        en_cyc = 0;
        if_foreign = 0;
        dm_foreign = 0;
        prev_en = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_a) begin
                if (mem_en_a) begin
                    chk("mem_en_single_cycle", 64'(prev_en), 64'd0);
                    chk("mem_addr_aligned", 64'(mem_addr_a[1:0]), 64'd0);
                    en_cyc = cyc;
                end
                prev_en = mem_en_a;
                if (if_ready_a) begin
                    chk("if_latency", 64'(cyc - en_cyc), 64'(LatA + 1));
                    if (if_q.size() == 0) begin
                        timeout_fail("if_ready_unexpected");
                    end else begin
                        want = if_q.pop_front();
                        chk("if_rdata", 64'(if_rdata_a), 64'(want));
                    end
                    if_foreign = 0;
                end
                if (dm_ready_a) begin
                    chk("dm_latency", 64'(cyc - en_cyc), 64'(LatA + 1));
                    if (dm_q.size() == 0) begin
                        timeout_fail("dm_ready_unexpected");
                    end else begin
                        it = dm_q.pop_front();
                        chk(it.we ? "dm_rdata_held_on_store" : "dm_rdata_load",
                            64'(dm_rdata_a), 64'(it.data));
                    end
                    dm_foreign = 0;
                end
                if (dm_ready_a && if_req_a && !if_ready_a) begin
                    if_foreign++;
                    chk("if_waits_at_most_one_dm", 64'(if_foreign > 1), 64'd0);
                end
                if (if_ready_a && dm_req_a && !dm_ready_a) begin
                    dm_foreign++;
                    chk("dm_waits_at_most_one_if", 64'(dm_foreign > 1), 64'd0);
                end
            end else begin
                prev_en = 1'b0;
            end
        end
    end

    task automatic wait_if_ready();
        int k;
        for (k = 0; k < 40; k++) begin
            nxt();
            if (if_ready_a) break;
        end
        if (k == 40) timeout_fail("if_ready_timeout");
    endtask

    task automatic wait_dm_ready();
        int k;
        for (k = 0; k < 40; k++) begin
            nxt();
            if (dm_ready_a) break;
        end
        if (k == 40) timeout_fail("dm_ready_timeout");
    endtask

    task automatic if_master(input int n, input bit nogap);
        for (int i = 0; i < n; i++) begin
            int unsigned w;
            if (!nogap) begin
                if_req_a = 1'b0;
                repeat ($urandom_range(0, 3)) nxt();
            end
            w = $urandom_range(0, 127);
            if_req_a  = 1'b1;
            if_addr_a = 32'(w * 4 + $urandom_range(0, 3));
            if_q.push_back(ref_mem[w]);
            wait_if_ready();
        end
        if_req_a = 1'b0;
    endtask

    // DM traffic stays in words 128..135 so it never overlaps concurrent IF reads.
    task automatic dm_master(input int n, input bit nogap);
        for (int i = 0; i < n; i++) begin
            int unsigned w;
            dm_item_t    it;
            if (!nogap) begin
                dm_req_a = 1'b0;
                repeat ($urandom_range(0, 3)) nxt();
            end
            w = 128 + $urandom_range(0, 7);
            dm_req_a   = 1'b1;
            dm_we_a    = 1'($urandom_range(0, 1));
            dm_addr_a  = 32'(w * 4 + $urandom_range(0, 3));
            dm_wdata_a = $urandom();
            if (dm_we_a) begin
                ref_mem[w] = dm_wdata_a;
            end else begin
                dm_last = ref_mem[w];
            end
            it.we   = dm_we_a;
            it.data = dm_last;
            dm_q.push_back(it);
            wait_dm_ready();
        end
        dm_req_a = 1'b0;
        dm_we_a  = 1'b0;
    endtask

    task automatic check_alternation(input int n);
        int prev;
        prev = -1;
        for (int k = 0; k < n; k++) begin
            int cnt;
            int owner;
            cnt = 0;
            do begin
                @(negedge clock);
                cnt++;
            end while (!if_ready_a && !dm_ready_a && cnt < 40);
            if (!if_ready_a && !dm_ready_a) begin
                timeout_fail("t4_alternation_timeout");
            end else begin
                owner = dm_ready_a ? 1 : 0;
                if (prev >= 0) chk("t4_grants_alternate", 64'(owner == prev), 64'd0);
                prev = owner;
            end
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset_a = 1'b1;
        reset_b = 1'b1;
        if_req_b = 1'b0; if_addr_b = '0; dm_req_b = 1'b0; dm_we_b = 1'b0;
        dm_addr_b = '0; dm_wdata_b = '0;

        // Tests 1 and 3: both requests held through reset, DM wins the first tie.
        if_req_a = 1'b1; if_addr_a = 32'h04;
        dm_req_a = 1'b1; dm_we_a = 1'b0; dm_addr_a = 32'h200; dm_wdata_a = '0;
        if_q.push_back(ref_mem[1]);
        dm_last = ref_mem[128];
        dm_q.push_back('{we: 1'b0, data: dm_last});
        repeat (3) begin
            smp();
            chk("t1_reset_ctrl", 64'({if_ready_a, dm_ready_a, mem_en_a, mem_we_a, stall_a}), 64'd0);
            chk("t1_reset_data", 64'(if_rdata_a | dm_rdata_a | mem_addr_a | mem_wdata_a), 64'd0);
        end
        nxt(); reset_a = 1'b0; reset_b = 1'b0;                          // cycle 0
        smp(); chk("t3_stall_c0", 64'(stall_a), 64'd1); chk("t3_mem_en_c0", 64'(mem_en_a), 64'd0);
        nxt(); smp();                                                   // cycle 1
        chk("t3_first_grant_en", 64'(mem_en_a), 64'd1);
        chk("t3_first_grant_dm", 64'(mem_addr_a), 64'h200);
        nxt(); nxt(); dm_req_a = 1'b0; smp();                           // cycle 3
        chk("t3_dm_ready_c3", 64'(dm_ready_a), 64'd1);
        chk("t3_stall_if_pending", 64'(stall_a), 64'd1);
        nxt(); smp();                                                   // cycle 4
        chk("t3_if_mem_en_c4", 64'(mem_en_a), 64'd1);
        chk("t3_if_mem_addr_c4", 64'(mem_addr_a), 64'h04);
        nxt(); nxt(); if_req_a = 1'b0; smp();                           // cycle 6
        chk("t3_if_ready_c6", 64'(if_ready_a), 64'd1);

        // Test 2: IF-only read at 0x08.
        nxt(); if_req_a = 1'b1; if_addr_a = 32'h08; if_q.push_back(ref_mem[2]);
        smp(); chk("t2_stall_c0", 64'(stall_a), 64'd1); chk("t2_mem_en_c0", 64'(mem_en_a), 64'd0);
        nxt(); smp();
        chk("t2_mem_en_c1", 64'(mem_en_a), 64'd1);
        chk("t2_mem_addr_c1", 64'(mem_addr_a), 64'h08);
        chk("t2_stall_c1", 64'(stall_a), 64'd1);
        nxt(); smp(); chk("t2_stall_c2", 64'(stall_a), 64'd1);
        nxt(); smp();
        chk("t2_if_ready_c3", 64'(if_ready_a), 64'd1);
        chk("t2_if_rdata_c3", 64'(if_rdata_a), 64'h8C02_0004);
        chk("t2_stall_c3", 64'(stall_a), 64'd0);
        nxt(); if_req_a = 1'b0; smp();
        chk("t2_masked_in_ready_cycle", 64'(mem_en_a), 64'd0);

        // Test 5: misaligned store.
        nxt(); dm_req_a = 1'b1; dm_we_a = 1'b1; dm_addr_a = 32'h13; dm_wdata_a = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        dm_q.push_back('{we: 1'b1, data: dm_last});
        nxt(); smp();
        chk("t5_mem_en", 64'(mem_en_a), 64'd1);
        chk("t5_mem_we", 64'(mem_we_a), 64'd1);
        chk("t5_mem_addr", 64'(mem_addr_a), 64'h10);
        chk("t5_mem_wdata", 64'(mem_wdata_a), 64'hDEAD_BEEF);
        nxt(); smp();
        chk("t5_we_one_cycle", 64'({mem_en_a, mem_we_a}), 64'd0);
        nxt(); dm_req_a = 1'b0; dm_we_a = 1'b0; smp();
        chk("t5_dm_ready", 64'(dm_ready_a), 64'd1);

        // Test 4: both ports saturated, grants must alternate.
        nxt();
        fork
            if_master(8, 1'b1);
            dm_master(8, 1'b1);
            check_alternation(15);
        join

        // Random traffic with gaps.
        nxt();
        fork
            if_master(40, 1'b0);
            dm_master(40, 1'b0);
        join
        repeat (4) nxt();

        // Test 6 on instance b (latency 3): a full read, then a read aborted by reset.
        nxt(); if_req_b = 1'b1; if_addr_b = 32'h0C;                    // cycle 0
        nxt(); smp();
        chk("t6_mem_en_c1", 64'(mem_en_b), 64'd1);
        chk("t6_mem_addr_c1", 64'(mem_addr_b), 64'h0C);
        nxt(); nxt(); nxt(); smp();                                     // cycle 4
        chk("t6_no_ready_c4", 64'(if_ready_b), 64'd0);
        nxt(); if_req_b = 1'b0; smp();                                  // cycle 5
        chk("t6_if_ready_c5", 64'(if_ready_b), 64'd1);
        chk("t6_if_rdata_c5", 64'(if_rdata_b), 64'(init_word(3)));
        nxt(); if_req_b = 1'b1; if_addr_b = 32'h24;                    // cycle 0
        nxt(); smp(); chk("t6b_mem_en_c1", 64'(mem_en_b), 64'd1);
        nxt();                                                          // first wait cycle
        nxt(); reset_b = 1'b1;                                          // second wait cycle
        nxt(); reset_b = 1'b0; if_req_b = 1'b0; smp();
        chk("t6_abort_ctrl", 64'({if_ready_b, dm_ready_b, mem_en_b, mem_we_b, stall_b}), 64'd0);
        chk("t6_abort_data", 64'(if_rdata_b | dm_rdata_b | mem_addr_b | mem_wdata_b), 64'd0);
        repeat (6) begin
            nxt(); smp();
            chk("t6_no_pulse_after_abort", 64'({if_ready_b, mem_en_b}), 64'd0);
        end

        chk("if_queue_drained", 64'(if_q.size()), 64'd0);
        chk("dm_queue_drained", 64'(dm_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
